mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the single four-bank main memory between the instruction-cache controller and the data-cache controller. Each cache controller holds ownership for a whole line transaction (up to 4 writebacks plus 4 fills). The arbiter forwards the owner's memory requests, routes returning read data back to that owner, and enforces a drain window on every ownership change so late read data always reaches the requester that issued the read. It sits between the two cache controllers and the four-bank memory model.

## Interface
- DRAIN_CYCLES, 2: memory read latency in cycles (rd_mem to valid data_out_mem); the length of the drain window; legal range 1–7.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_i  in  1  I-cache requests ownership; held high for the whole transaction
- rd_i, wr_i  in  1 each  I-cache memory read / write strobes
- addr_i  in  16  I-cache memory address
- data_in_i  in  16  I-cache write data
- grant_i  out  1  I-cache owns memory (registered)
- stall_i  out  1  I-cache must hold its current access
- data_out_i  out  16  read data routed to I-cache
- req_d, rd_d, wr_d, addr_d, data_in_d, grant_d, stall_d, data_out_d: same as the I-cache ports, for the D-cache
- addr_mem  out  16  memory address
- data_in_mem  out  16  memory write data
- rd_mem, wr_mem  out  1 each  memory strobes
- data_out_mem  in  16  memory read data
- stall_mem  in  1  memory busy (bank conflict)
- err  out  1  one-cycle pulse on a protocol violation by the owner

## Operation
- The FSM has four states: IDLE, OWN_I, OWN_D, DRAIN.
- Registered state:
  - a 3-bit drain counter
  - last_owner (0 = I, 1 = D)
  - route (the owner whose read data is still in flight)
- IDLE:
  - If only req_d is high, go to OWN_D. If only req_i is high, go to OWN_I.
  - If both are high, grant the requester that is not last_owner (round robin).
  - last_owner resets to I, so D wins the first tie.
- OWN_x:
  - grant_x = 1.
  - rd_mem = rd_x, wr_mem = wr_x, addr_mem = addr_x, data_in_mem = data_in_x, all combinational.
  - stall_x = stall_mem.
  - When req_x is low: go to DRAIN, load counter = DRAIN_CYCLES − 1, set last_owner = x.
- DRAIN:
  - No grants are active; rd_mem = wr_mem = 0.
  - The counter decrements each cycle.
  - When the counter is 0, re-arbitrate exactly as in IDLE (go directly to OWN_y if any req is high, otherwise go to IDLE).
- route follows the owner in OWN_x and is held through DRAIN.
  - data_out_x = data_out_mem when route = x, otherwise 16'h0000.
- Non-owner:
  - Its rd/wr are never forwarded.
  - stall_y = 1 whenever req_y | rd_y | wr_y, otherwise 0.
- Protocol violations:
  - If the owner asserts rd_x & wr_x together: err = 1 for that cycle and both are blocked (rd_mem = wr_mem = 0).
  - Strobes with req low are ignored and raise no err.
- When no owner is active: addr_mem and data_in_mem = 16'h0000 and rd_mem = wr_mem = 0.

## Timing
- Reset (rst high at a clk edge):
  - state = IDLE, last_owner = I, route = I, counter = 0.
  - grant_i = grant_d = 0, err = 0.
  - While rst is high, rd_mem and wr_mem are forced to 0 combinationally.
- Reset mid-transaction: ownership is dropped at that edge with no drain. In-flight read data is discarded because the cache controllers are also reset.
- Grant latency: req sampled high in IDLE at edge k gives grant high during cycle k+1. The owner's first strobe is forwarded in that same cycle.
- Release: req low sampled at edge n gives grant low from cycle n+1. The next grant is asserted at cycle n+1+DRAIN_CYCLES.
- Ownership changeover: there is no back-to-back owner without a drain window, even when the same requester re-requests.
- Requests during drain:
  - A req asserted during DRAIN is not lost; it is served at drain end.
  - If both requesters are pending at drain end, round robin picks the requester other than the one just released.
- stall_mem while owned: the owner must hold its strobes and operands. The arbiter adds no cycles of its own.
- err is combinational, driven from the current strobes, and is not sticky.

## Test plan
- Single D request: req_d = 1 at cycle 0, rd_d with addr_d = 16'h1230. Expect grant_d in cycle 1, rd_mem = 1, addr_mem = 16'h1230. Memory returns 16'hBEEF at cycle 1+DRAIN_CYCLES; expect data_out_d = 16'hBEEF and data_out_i = 0.
- Tie after reset: req_i = req_d = 1 in the same cycle. Expect grant_d first. D releases; after 2 drain cycles expect grant_i, with no gap beyond DRAIN_CYCLES.
- Drain routing: D issues rd in its last owned cycle, then drops req while req_i is high. Data arriving during DRAIN goes to data_out_d only. grant_i rises exactly 2 cycles after grant_d falls.
- Non-owner blocking: during OWN_I, D asserts wr_d with data 16'h00FF. Expect wr_mem to follow only wr_i, stall_d = 1, and memory contents unchanged for D's address.
- Violation: the owner asserts rd and wr together. Expect err = 1 for one cycle and rd_mem = wr_mem = 0. Also assert rst mid-OWN_D: expect grant_d = 0 and state IDLE on the next edge.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single four-bank main memory between the I-cache and D-cache
// controllers. A controller owns memory for a whole line transaction (held
// req). The owner's strobes and operands are forwarded to memory. Read data
// goes back to whichever controller issued the read. Every ownership change
// passes through a drain window as long as the memory read latency, so late
// read data still reaches the controller that requested it.
//
// Parameters:
//   DRAIN_CYCLES  memory read latency in cycles (1..7); drain window length
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_i/rd_i/wr_i              I-cache ownership request and memory strobes
//   addr_i/data_in_i             I-cache address and write data
//   grant_i/stall_i/data_out_i   I-cache grant, stall and routed read data
//   req_d ... data_out_d         the same set for the D-cache
//   addr_mem/data_in_mem         memory address and write data
//   rd_mem/wr_mem                memory strobes
//   data_out_mem/stall_mem       memory read data and busy flag
//   err                          one-cycle pulse on an owner protocol violation
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  // I-cache side
  input  logic        req_i,
  input  logic        rd_i,
  input  logic        wr_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] data_in_i,
  output logic        grant_i,
  output logic        stall_i,
  output logic [15:0] data_out_i,
  // D-cache side
  input  logic        req_d,
  input  logic        rd_d,
  input  logic        wr_d,
  input  logic [15:0] addr_d,
  input  logic [15:0] data_in_d,
  output logic        grant_d,
  output logic        stall_d,
  output logic [15:0] data_out_d,
  // memory side
  output logic [15:0] addr_mem,
  output logic [15:0] data_in_mem,
  output logic        rd_mem,
  output logic        wr_mem,
  input  logic [15:0] data_out_mem,
  input  logic        stall_mem,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       last_owner_q, last_owner_d;
  logic       route_q, route_d;

  // Round robin: with both requests up, the controller that did not own
  // memory last wins. last_owner resets to I, so D wins the first tie.
  function automatic state_e arbitrate(input logic ri, input logic rq_d,
                                       input logic last);
    state_e nxt;
    nxt = IDLE;
    if (ri && rq_d)  nxt = (last == OWNER_I) ? OWN_D : OWN_I;
    else if (rq_d)   nxt = OWN_D;
    else if (ri)     nxt = OWN_I;
    return nxt;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    route_d      = route_q;

    unique case (state_q)
      IDLE: state_d = arbitrate(req_i, req_d, last_owner_q);
      OWN_I: begin
        if (!req_i) begin
          state_d      = DRAIN;
          cnt_d        = 3'(DRAIN_CYCLES - 1);
          last_owner_d = OWNER_I;
        end
      end
      OWN_D: begin
        if (!req_d) begin
          state_d      = DRAIN;
          cnt_d        = 3'(DRAIN_CYCLES - 1);
          last_owner_d = OWNER_D;
        end
      end
      DRAIN: begin
        // Drain end re-arbitrates directly, so a request raised during the
        // window is served without an extra IDLE cycle.
        if (cnt_q == 3'd0) state_d = arbitrate(req_i, req_d, last_owner_q);
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase

    // route follows the owner and is simply held through DRAIN and IDLE, so
    // reads issued in the last owned cycles still land at their requester.
    if (state_d == OWN_I)      route_d = OWNER_I;
    else if (state_d == OWN_D) route_d = OWNER_D;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      last_owner_q <= OWNER_I;
      route_q      <= OWNER_I;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      route_q      <= route_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath / outputs
  // ---------------------------------------------------------------------------
  assign grant_i = (state_q == OWN_I);
  assign grant_d = (state_q == OWN_D);

  assign data_out_i = (route_q == OWNER_I) ? data_out_mem : 16'h0000;
  assign data_out_d = (route_q == OWNER_D) ? data_out_mem : 16'h0000;

  logic rd_fwd, wr_fwd, err_raw;

  always_comb begin
    addr_mem    = 16'h0000;
    data_in_mem = 16'h0000;
    rd_fwd      = 1'b0;
    wr_fwd      = 1'b0;
    err_raw     = 1'b0;
    // A non-owner that wants memory is held off.
    stall_i     = req_i | rd_i | wr_i;
    stall_d     = req_d | rd_d | wr_d;

    unique case (state_q)
      OWN_I: begin
        addr_mem    = addr_i;
        data_in_mem = data_in_i;
        stall_i     = stall_mem;
        // Strobes only count while req is held; rd+wr together is blocked.
        if (req_i) begin
          if (rd_i && wr_i) err_raw = 1'b1;
          else begin
            rd_fwd = rd_i;
            wr_fwd = wr_i;
          end
        end
      end
      OWN_D: begin
        addr_mem    = addr_d;
        data_in_mem = data_in_d;
        stall_d     = stall_mem;
        if (req_d) begin
          if (rd_d && wr_d) err_raw = 1'b1;
          else begin
            rd_fwd = rd_d;
            wr_fwd = wr_d;
          end
        end
      end
      default: ;
    endcase
  end

  // Reset kills memory strobes immediately, before the state has cleared.
  assign rd_mem = rd_fwd & ~rst;
  assign wr_mem = wr_fwd & ~rst;
  assign err    = err_raw & ~rst;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int unsigned DRAIN = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, rd_i, wr_i, req_d, rd_d, wr_d;
  logic [15:0] addr_i, data_in_i, addr_d, data_in_d;
  logic        grant_i, stall_i, grant_d, stall_d;
  logic [15:0] data_out_i, data_out_d;
  logic [15:0] addr_mem, data_in_mem, data_out_mem;
  logic        rd_mem, wr_mem, stall_mem, err;

  always #5 clk = ~clk;

  mem_arbiter #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst),
    .req_i(req_i), .rd_i(rd_i), .wr_i(wr_i), .addr_i(addr_i),
    .data_in_i(data_in_i), .grant_i(grant_i), .stall_i(stall_i),
    .data_out_i(data_out_i),
    .req_d(req_d), .rd_d(rd_d), .wr_d(wr_d), .addr_d(addr_d),
    .data_in_d(data_in_d), .grant_d(grant_d), .stall_d(stall_d),
    .data_out_d(data_out_d),
    .addr_mem(addr_mem), .data_in_mem(data_in_mem),
    .rd_mem(rd_mem), .wr_mem(wr_mem),
    .data_out_mem(data_out_mem), .stall_mem(stall_mem), .err(err)
  );

  // One row = one clock cycle: inputs held for the cycle, outputs expected
  // mid-cycle.
  typedef struct packed {
    logic        rst;
    logic        req_i, rd_i, wr_i;
    logic [15:0] addr_i, din_i;
    logic        req_d, rd_d, wr_d;
    logic [15:0] addr_d, din_d;
    logic [15:0] dmem;
    logic        smem;
    logic        e_gi, e_gd, e_si, e_sd, e_rd, e_wr;
    logic [15:0] e_addr, e_din, e_oi, e_od;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [70:0] got,
                       input logic [70:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [70:0] outs();
    return {grant_i, grant_d, stall_i, stall_d, rd_mem, wr_mem,
            addr_mem, data_in_mem, data_out_i, data_out_d, err};
  endfunction

  task automatic apply(input vec_t v);
    rst = v.rst;
    req_i = v.req_i; rd_i = v.rd_i; wr_i = v.wr_i;
    addr_i = v.addr_i; data_in_i = v.din_i;
    req_d = v.req_d; rd_d = v.rd_d; wr_d = v.wr_d;
    addr_d = v.addr_d; data_in_d = v.din_d;
    data_out_mem = v.dmem; stall_mem = v.smem;
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    check(name, {70'd0, got}, {70'd0, exp});
  endtask

  initial begin
    vec_t idle_v;
    int   lat;

    //        rst  req_i rd wr addr_i   din_i    req_d rd wr addr_d   din_d    dmem     smem  gi gd si sd rd wr e_addr   e_din    e_oi     e_od     err
    // reset cycle, D strobing: nothing forwarded, stall_d from req|rd
    tbl.push_back(vec_t'{1'b1, 1'b0,1'b0,1'b0, 16'h0000,16'h0000, 1'b1,1'b1,1'b0, 16'h1230,16'h0000, 16'h0000,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 16'h0000,16'h0000,16'h0000,16'h0000,1'b0});
    // single D request: IDLE cycle
    tbl.push_back(vec_t'{1'b0, 1'b0,1'b0,1'b0, 16'h0000,16'h0000, 1'b1,1'b1,1'b0, 16'h1230,16'h0000, 16'h0000,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 16'h0000,16'h0000,16'h0000,16'h0000,1'b0});
    // grant_d, rd forwarded in the same cycle
    tbl.push_back(vec_t'{1'b0, 1'b0,1'b0,1'b0, 16'h0000,16'h0000, 1'b1,1'b1,1'b0, 16'h1230,16'h0000, 16'h0000,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, 16'h1230,16'h0000,16'h0000,16'h0000,1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0,1'b0,1'b0, 16'h0000,16'h0000, 1'b1,1'b0,1'b0, 16'h1230,16'h0000, 16'h0000,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 16'h1230,16'h0000,16'h0000,16'h0000,1'b0});
    // read data returns to D only; stall_mem passes to owner
    tbl.push_back(vec_t'{1'b0, 1'b0,1'b0,1'b0, 16'h0000,16'h0000, 1'b1,1'b0,1'b0, 16'h1230,16'h0000, 16'hBEEF,1'b1, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 16'h1230,16'h0000,16'h0000,16'hBEEF,1'b0});
    // D releases
    tbl.push_back(vec_t'{1'b0, 1'b0,1'b0,1'b0, 16'h0000,16'h0000, 1'b0,1'b0,1'b0, 16'h1230,16'h0000, 16'h0000,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 16'h1230,16'h0000,16'h0000,16'h0000,1'b0});
    idle_v = vec_t'{1'b0, 1'b0,1'b0,1'b0, 16'h0000,16'h0000, 1'b0,1'b0,1'b0, 16'h0000,16'h0000, 16'h0000,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 16'h0000,16'h0000,16'h0000,16'h0000,1'b0};
    tbl.push_back(idle_v);   // DRAIN
    tbl.push_back(idle_v);   // DRAIN
    tbl.push_back(idle_v);   // IDLE
    // reset restores last_owner = I
    tbl.push_back(vec_t'{1'b1, 1'b0,1'b0,1'b0, 16'h0000,16'h0000, 1'b0,1'b0,1'b0, 16'h0000,16'h0000, 16'h0000,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 16'h0000,16'h0000,16'h0000,16'h0000,1'b0});
    // tie after reset
    tbl.push_back(vec_t'{1'b0, 1'b1,1'b0,1'b0, 16'h0000,16'h0000, 1'b1,1'b0,1'b0, 16'h0000,16'h0000, 16'h0000,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 16'h0000,16'h0000,16'h0000,16'h0000,1'b0});
    // D wins the tie, issues rd in its last owned cycle
    tbl.push_back(vec_t'{1'b0, 1'b1,1'b0,1'b0, 16'h0000,16'h0000, 1'b1,1'b1,1'b0, 16'h0040,16'h0000, 16'h0000,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b1,1'b0, 16'h0040,16'h0000,16'h0000,16'h0000,1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b1,1'b0,1'b0, 16'h0000,16'h0000, 1'b0,1'b0,1'b0, 16'h0040,16'h0000, 16'h0000,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 16'h0040,16'h0000,16'h0000,16'h0000,1'b0});
    // drain: late data still routed to D
    tbl.push_back(vec_t'{1'b0, 1'b1,1'b0,1'b0, 16'h0000,16'h0000, 1'b0,1'b0,1'b0, 16'h0000,16'h0000, 16'h1111,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 16'h0000,16'h0000,16'h0000,16'h1111,1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b1,1'b0,1'b0, 16'h0000,16'h0000, 1'b0,1'b0,1'b0, 16'h0000,16'h0000, 16'h2222,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 16'h0000,16'h0000,16'h0000,16'h2222,1'b0});
    // OWN_I: I writes, D's wr_d 00FF blocked and stalled
    tbl.push_back(vec_t'{1'b0, 1'b1,1'b0,1'b1, 16'h0100,16'h1234, 1'b0,1'b0,1'b1, 16'h0200,16'h00FF, 16'h3333,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b1, 16'h0100,16'h1234,16'h3333,16'h0000,1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b1,1'b0,1'b0, 16'h0100,16'h1234, 1'b0,1'b0,1'b1, 16'h0200,16'h00FF, 16'h0000,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 16'h0100,16'h1234,16'h0000,16'h0000,1'b0});
    // violation: rd+wr together
    tbl.push_back(vec_t'{1'b0, 1'b1,1'b1,1'b1, 16'h0100,16'h1234, 1'b0,1'b0,1'b0, 16'h0000,16'h0000, 16'h0000,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 16'h0100,16'h1234,16'h0000,16'h0000,1'b1});
    // err not sticky
    tbl.push_back(vec_t'{1'b0, 1'b1,1'b1,1'b0, 16'h0100,16'h1234, 1'b0,1'b0,1'b0, 16'h0000,16'h0000, 16'h0000,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 16'h0100,16'h1234,16'h0000,16'h0000,1'b0});
    // strobes with req low ignored, no err
    tbl.push_back(vec_t'{1'b0, 1'b0,1'b1,1'b1, 16'h0100,16'h1234, 1'b0,1'b0,1'b0, 16'h0000,16'h0000, 16'h0000,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 16'h0100,16'h1234,16'h0000,16'h0000,1'b0});
    // both request during drain
    tbl.push_back(vec_t'{1'b0, 1'b1,1'b0,1'b0, 16'h0000,16'h0000, 1'b1,1'b0,1'b0, 16'h0000,16'h0000, 16'h0000,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 16'h0000,16'h0000,16'h0000,16'h0000,1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b1,1'b0,1'b0, 16'h0000,16'h0000, 1'b1,1'b0,1'b0, 16'h0000,16'h0000, 16'h0000,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 16'h0000,16'h0000,16'h0000,16'h0000,1'b0});
    // round robin picks D (I just released)
    tbl.push_back(vec_t'{1'b0, 1'b1,1'b0,1'b0, 16'h0000,16'h0000, 1'b1,1'b0,1'b1, 16'h0300,16'h00AA, 16'h0000,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b1, 16'h0300,16'h00AA,16'h0000,16'h0000,1'b0});
    // rst mid-OWN_D: strobes and err forced low at once
    tbl.push_back(vec_t'{1'b1, 1'b1,1'b0,1'b0, 16'h0000,16'h0000, 1'b1,1'b1,1'b1, 16'h0300,16'h00AA, 16'h0000,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 16'h0300,16'h00AA,16'h0000,16'h0000,1'b0});
    // IDLE after reset, route back to I
    tbl.push_back(vec_t'{1'b0, 1'b0,1'b0,1'b0, 16'h0000,16'h0000, 1'b0,1'b0,1'b0, 16'h0000,16'h0000, 16'h4444,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 16'h0000,16'h0000,16'h4444,16'h0000,1'b0});
    // same requester re-requests: drain still enforced
    tbl.push_back(vec_t'{1'b0, 1'b0,1'b0,1'b0, 16'h0000,16'h0000, 1'b1,1'b0,1'b0, 16'h0000,16'h0000, 16'h0000,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 16'h0000,16'h0000,16'h0000,16'h0000,1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0,1'b0,1'b0, 16'h0000,16'h0000, 1'b0,1'b0,1'b0, 16'h0000,16'h0000, 16'h0000,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 16'h0000,16'h0000,16'h0000,16'h0000,1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0,1'b0,1'b0, 16'h0000,16'h0000, 1'b1,1'b0,1'b0, 16'h0000,16'h0000, 16'h0000,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 16'h0000,16'h0000,16'h0000,16'h0000,1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0,1'b0,1'b0, 16'h0000,16'h0000, 1'b1,1'b0,1'b0, 16'h0000,16'h0000, 16'h0000,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 16'h0000,16'h0000,16'h0000,16'h0000,1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0,1'b0,1'b0, 16'h0000,16'h0000, 1'b1,1'b0,1'b0, 16'h0000,16'h0000, 16'h0000,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 16'h0000,16'h0000,16'h0000,16'h0000,1'b0});

    // Preamble reset so the first table row sees a defined state.
    apply(idle_v);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[k]) begin
      apply(tbl[k]);
      @(negedge clk);
      check($sformatf("vec%0d", k), outs(),
            {tbl[k].e_gi, tbl[k].e_gd, tbl[k].e_si, tbl[k].e_sd,
             tbl[k].e_rd, tbl[k].e_wr, tbl[k].e_addr, tbl[k].e_din,
             tbl[k].e_oi, tbl[k].e_od, tbl[k].e_err});
      @(posedge clk);
      #1;
    end

    // Hand sequence: D (owner) releases while I requests; grant_i must
    // appear exactly 1 + DRAIN edges later with grant_d low throughout.
    req_d = 1'b0;
    req_i = 1'b1;
    @(negedge clk);
    check1("handoff_grant_d_release_cycle", grant_d, 1'b1);
    lat = 0;
    while (lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
      if (grant_i) break;
      check1($sformatf("handoff_grant_d_low_%0d", lat), grant_d, 1'b0);
    end
    check("handoff_latency", 71'(lat), 71'(1 + DRAIN));
    check1("handoff_grant_i_held", grant_i, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
